// File: rtl/ahb_defs.sv
// Shared AHB encodings and arbiter constants for the two-master arbiter.
package ahb_defs;

  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned HBURST_W = 3;
  localparam int unsigned CNT_W    = 4;

  // Arbitration policy selectors for PRIO_MODE.
  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  typedef enum logic [HTRANS_W-1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [HBURST_W-1:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_e;

endpackage

// File: rtl/ahb_burst_cnt.sv
// Remaining-beat counter for the current burst plus the HBURST decode.
// o_hold_c flags that the burst still has beats left and the owner is
// continuing it (SEQ/BUSY); IDLE or NONSEQ ends the burst early.
module ahb_burst_cnt
  import ahb_defs::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_hready,
  input  logic [HTRANS_W-1:0] i_htrans,
  input  logic [HBURST_W-1:0] i_hburst,
  output logic                o_hold_c
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load;

  // Beats-minus-one for a new burst; undefined-length bursts count as single.
  always_comb begin
    w_load = '0;
    case (hburst_e'(i_hburst))
      HB_WRAP4,  HB_INCR4:  w_load = CNT_W'(3);
      HB_WRAP8,  HB_INCR8:  w_load = CNT_W'(7);
      HB_WRAP16, HB_INCR16: w_load = CNT_W'(15);
      default:              w_load = '0;
    endcase
  end

  // Counter update on completed address phases only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_hready) begin
      case (htrans_e'(i_htrans))
        HT_NONSEQ: r_cnt <= w_load;
        HT_SEQ:    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        HT_IDLE:   r_cnt <= '0;
        default:   r_cnt <= r_cnt;
      endcase
    end
  end

  // Burst in progress and not being terminated on this cycle.
  assign o_hold_c = (r_cnt != '0) &&
                    ((i_htrans == HT_SEQ) || (i_htrans == HT_BUSY));

endmodule

// File: rtl/ahb_arb_m2.sv
// Two-master AHB arbiter: fixed-priority or round-robin grant, burst and
// lock hold, and the grant -> address -> data owner pipeline.
module ahb_arb_m2
  import ahb_defs::*;
#(
  parameter int unsigned PRIO_MODE  = PRIO_FIXED,
  parameter int unsigned DEF_MASTER = 0
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                M0_HBUSREQ,
  input  logic                M1_HBUSREQ,
  input  logic                M0_HLOCK,
  input  logic                M1_HLOCK,
  input  logic [HTRANS_W-1:0] HTRANS,
  input  logic [HBURST_W-1:0] HBURST,
  input  logic                HREADY,
  output logic                M0_HGRANT,
  output logic                M1_HGRANT,
  output logic                HMASTER,
  output logic                HMASTER_D,
  output logic                HMASTLOCK
);

  localparam logic LP_DEF = 1'(DEF_MASTER);

  logic r_grant;
  logic r_rr_ptr;
  logic r_hmaster;
  logic r_hmaster_d;
  logic r_hmastlock;

  logic w_burst_hold;
  logic w_lock_g;
  logic w_hold;
  logic w_next_grant;
  logic w_win_req;

  ahb_burst_cnt u_burst_cnt (
    .i_clk    (HCLK),
    .i_rst_n  (HRESETn),
    .i_hready (HREADY),
    .i_htrans (HTRANS),
    .i_hburst (HBURST),
    .o_hold_c (w_burst_hold)
  );

  assign w_lock_g = r_grant ? M1_HLOCK : M0_HLOCK;
  assign w_hold   = w_burst_hold || w_lock_g;

  // Winner selection; round-robin only matters when both masters request.
  always_comb begin
    w_next_grant = LP_DEF;
    w_win_req    = 1'b0;
    if ((PRIO_MODE == PRIO_RR) && M0_HBUSREQ && M1_HBUSREQ) begin
      w_next_grant = ~r_rr_ptr;
      w_win_req    = 1'b1;
    end else if (M1_HBUSREQ) begin
      w_next_grant = 1'b1;
      w_win_req    = 1'b1;
    end else if (M0_HBUSREQ) begin
      w_next_grant = 1'b0;
      w_win_req    = 1'b1;
    end
  end

  // Grant, owner pipeline and lock state, advanced only when HREADY is high.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_grant     <= LP_DEF;
      r_rr_ptr    <= LP_DEF;
      r_hmaster   <= LP_DEF;
      r_hmaster_d <= LP_DEF;
      r_hmastlock <= 1'b0;
    end else if (HREADY) begin
      r_hmaster   <= r_grant;
      r_hmaster_d <= r_hmaster;
      r_hmastlock <= w_lock_g;
      if (!w_hold) begin
        r_grant <= w_next_grant;
        if (w_win_req) r_rr_ptr <= w_next_grant;
      end
    end
  end

  assign M0_HGRANT = ~r_grant;
  assign M1_HGRANT = r_grant;
  assign HMASTER   = r_hmaster;
  assign HMASTER_D = r_hmaster_d;
  assign HMASTLOCK = r_hmastlock;

endmodule

// File: tb/tb_ahb_arb_m2.sv
// Bench for ahb_arb_m2: fixed-priority and round-robin instances on shared
// stimulus, a cycle model of the arbitration rules, and directed scenarios.
module tb_ahb_arb_m2;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       M0_HBUSREQ, M1_HBUSREQ, M0_HLOCK, M1_HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;

  // Index 0 = fixed-priority instance, 1 = round-robin instance.
  logic g0 [2];
  logic g1 [2];
  logic hm [2];
  logic hmd[2];
  logic ml [2];

  int n_chk = 0;
  int n_err = 0;

  ahb_arb_m2 #(.PRIO_MODE(0), .DEF_MASTER(0)) u_fix (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HBUSREQ(M0_HBUSREQ), .M1_HBUSREQ(M1_HBUSREQ),
    .M0_HLOCK(M0_HLOCK), .M1_HLOCK(M1_HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .M0_HGRANT(g0[0]), .M1_HGRANT(g1[0]),
    .HMASTER(hm[0]), .HMASTER_D(hmd[0]), .HMASTLOCK(ml[0])
  );

  ahb_arb_m2 #(.PRIO_MODE(1), .DEF_MASTER(0)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HBUSREQ(M0_HBUSREQ), .M1_HBUSREQ(M1_HBUSREQ),
    .M0_HLOCK(M0_HLOCK), .M1_HLOCK(M1_HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .M0_HGRANT(g0[1]), .M1_HGRANT(g1[1]),
    .HMASTER(hm[1]), .HMASTER_D(hmd[1]), .HMASTLOCK(ml[1])
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_grant[2], m_hm[2], m_hmd[2], m_ml[2], m_rem[2], m_last[2];
  bit m_valid = 1'b0;
  int lock_g, win;
  bit win_req, in_burst;

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      m_valid = 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_grant[m] = 0; m_hm[m] = 0; m_hmd[m] = 0;
        m_ml[m] = 0; m_rem[m] = 0; m_last[m] = 0;
      end
    end else if (HREADY) begin
      for (int m = 0; m < 2; m++) begin
        lock_g   = (m_grant[m] == 1) ? int'(M1_HLOCK) : int'(M0_HLOCK);
        in_burst = (m_rem[m] > 0) && (HTRANS == 2'b11 || HTRANS == 2'b01);
        win_req  = M0_HBUSREQ || M1_HBUSREQ;
        if (M0_HBUSREQ && M1_HBUSREQ) win = (m == 1) ? 1 - m_last[m] : 1;
        else if (M1_HBUSREQ)          win = 1;
        else                          win = 0;
        m_hmd[m] = m_hm[m];
        m_hm[m]  = m_grant[m];
        m_ml[m]  = lock_g;
        if (!in_burst && lock_g == 0) begin
          m_grant[m] = win;
          if (win_req) m_last[m] = win;
        end
        case (HTRANS)
          2'b10:   m_rem[m] = burst_len(HBURST) - 1;
          2'b11:   if (m_rem[m] > 0) m_rem[m] = m_rem[m] - 1;
          2'b00:   m_rem[m] = 0;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge HCLK) begin
    if (m_valid) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("mdl%0d_m0_hgrant", m), int'(g0[m]), int'(m_grant[m] == 0));
        chk($sformatf("mdl%0d_m1_hgrant", m), int'(g1[m]), int'(m_grant[m] == 1));
        chk($sformatf("mdl%0d_hmaster", m), int'(hm[m]), m_hm[m]);
        chk($sformatf("mdl%0d_hmaster_d", m), int'(hmd[m]), m_hmd[m]);
        chk($sformatf("mdl%0d_hmastlock", m), int'(ml[m]), m_ml[m]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    HRESETn = 1'b0; M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b0;
    M0_HLOCK = 1'b0; M1_HLOCK = 1'b0;
    HTRANS = 2'b00; HBURST = 3'b000; HREADY = 1'b1;

    // Reset values
    step(2);
    chk("rst_m0_hgrant", int'(g0[0]), 1);
    chk("rst_m1_hgrant", int'(g1[0]), 0);
    chk("rst_hmaster", int'(hm[0]), 0);
    chk("rst_hmaster_d", int'(hmd[0]), 0);
    chk("rst_hmastlock", int'(ml[0]), 0);

    // Fixed priority and pipeline latency
    HRESETn = 1'b1; M0_HBUSREQ = 1'b1; M1_HBUSREQ = 1'b1;
    step(1);
    chk("fix_grant_e1", int'(g1[0]), 1);
    chk("fix_hmaster_e1", int'(hm[0]), 0);
    step(1);
    chk("fix_hmaster_e2", int'(hm[0]), 1);
    chk("fix_hmaster_d_e2", int'(hmd[0]), 0);
    step(1);
    chk("fix_hmaster_d_e3", int'(hmd[0]), 1);

    // Burst hold with a wait state
    M1_HBUSREQ = 1'b0;
    step(3);
    chk("burst_own_m0", int'(g0[0]), 1);
    chk("burst_own_hmd", int'(hmd[0]), 0);
    HTRANS = 2'b10; HBURST = 3'b011;
    step(1);
    chk("burst_beat1", int'(g1[0]), 0);
    HTRANS = 2'b11; M1_HBUSREQ = 1'b1;
    step(1);
    chk("burst_beat2", int'(g1[0]), 0);
    HREADY = 1'b0;
    step(1);
    chk("burst_wait", int'(g1[0]), 0);
    HREADY = 1'b1;
    step(1);
    chk("burst_beat3", int'(g1[0]), 0);
    step(1);
    chk("burst_beat4", int'(g1[0]), 0);
    HTRANS = 2'b00;
    step(1);
    chk("burst_handover", int'(g1[0]), 1);

    // Early termination of INCR8
    M1_HBUSREQ = 1'b0;
    step(3);
    chk("early_own_m0", int'(g0[0]), 1);
    HTRANS = 2'b10; HBURST = 3'b101;
    step(1);
    chk("early_beat1", int'(g0[0]), 1);
    HTRANS = 2'b11; M1_HBUSREQ = 1'b1;
    step(1);
    chk("early_beat2", int'(g0[0]), 1);
    step(1);
    chk("early_beat3", int'(g0[0]), 1);
    HTRANS = 2'b00;
    step(1);
    chk("early_term", int'(g1[0]), 1);

    // Locked ownership
    M1_HBUSREQ = 1'b0;
    step(3);
    M0_HLOCK = 1'b1; M1_HBUSREQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("lock_keep_grant", int'(g0[0]), 1);
      chk("lock_mastlock", int'(ml[0]), 1);
      chk("lock_hmaster", int'(hm[0]), 0);
    end
    M0_HLOCK = 1'b0;
    step(1);
    chk("unlock_grant", int'(g1[0]), 1);
    chk("unlock_mastlock", int'(ml[0]), 0);
    step(1);
    chk("unlock_hmaster", int'(hm[0]), 1);

    // Round-robin alternation
    HRESETn = 1'b0; M1_HBUSREQ = 1'b0; M0_HBUSREQ = 1'b0; HTRANS = 2'b00;
    step(2);
    chk("rr_rst_grant", int'(g0[1]), 1);
    HRESETn = 1'b1; M0_HBUSREQ = 1'b1; M1_HBUSREQ = 1'b1;
    HTRANS = 2'b10; HBURST = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk($sformatf("rr_alt_%0d", i), int'(g1[1]), int'(i % 2 == 0));
    end

    // Reset in the middle of an INCR16 held by M1
    HBURST = 3'b111;
    step(1);
    chk("rr_incr16_start", int'(g1[1]), 1);
    HTRANS = 2'b11;
    step(1);
    chk("rr_incr16_hold1", int'(g1[1]), 1);
    step(1);
    chk("rr_incr16_hold2", int'(g1[1]), 1);
    HRESETn = 1'b0;
    step(1);
    chk("rr_midrst_grant", int'(g0[1]), 1);
    chk("rr_midrst_hmaster", int'(hm[1]), 0);
    HRESETn = 1'b1;
    step(1);
    chk("rr_post_rst_arb", int'(g1[1]), 1);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 300; i++) begin
      M0_HBUSREQ = 1'($urandom_range(0, 1));
      M1_HBUSREQ = 1'($urandom_range(0, 1));
      M0_HLOCK   = 1'($urandom_range(0, 7) == 0);
      M1_HLOCK   = 1'($urandom_range(0, 7) == 0);
      HTRANS     = 2'($urandom_range(0, 3));
      HBURST     = 3'($urandom_range(0, 7));
      HREADY     = 1'($urandom_range(0, 3) != 0);
      HRESETn    = 1'($urandom_range(0, 49) != 0);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_arb_m2.md
AHB_ARB_M2 -- requirements
Module: ahb_arb_m2

Interface
REQ-001 Parameter PRIO_MODE, default 0: 0 = fixed priority (M1 data port above M0 instruction port); 1 = round-robin.
REQ-002 Parameter DEF_MASTER, default 0: master granted when no request is pending.
REQ-003 HCLK  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-004 HRESETn  input  1  reset, synchronous, active-low.
REQ-005 M0_HBUSREQ, M1_HBUSREQ  input  1 each  bus requests.
REQ-006 M0_HLOCK, M1_HLOCK  input  1 each  locked-transfer requests.
REQ-007 HTRANS  input  2  muxed slave-side transfer type of the current address-phase owner.
REQ-008 HBURST  input  3  muxed slave-side burst type of the current address-phase owner.
REQ-009 HREADY  input  1  system HREADY; 1 ends the current data phase.
REQ-010 M0_HGRANT, M1_HGRANT  output  1 each  grants; exactly one high at all times (one-hot).
REQ-011 HMASTER  output  1  address-phase owner; drives the address/control mux.
REQ-012 HMASTER_D  output  1  data-phase owner; drives the HWDATA mux and HRDATA/HREADY routing.
REQ-013 HMASTLOCK  output  1  the current address phase is locked.

Function
REQ-014 Grant state is registered; a grant change takes effect only on an edge where HREADY=1 and the hold condition (REQ-018) is false.
REQ-015 Fixed mode arbitration: M1 if M1_HBUSREQ, else M0 if M0_HBUSREQ, else DEF_MASTER.
REQ-016 Round-robin mode arbitration: if both masters request, grant the master other than the last-granted requester; if one requests, grant it; if none request, grant DEF_MASTER. The round-robin pointer updates only when a requesting master wins.
REQ-017 HMASTER loads the granted index on each edge with HREADY=1. HMASTER_D loads HMASTER on each edge with HREADY=1. This gives a one-cycle grant-to-address pipeline and an address-to-data pipeline.
REQ-018 Hold, with no re-arbitration, while either of these is true:
  - the beat counter is nonzero;
  - the granted master's HLOCK is 1.
REQ-019 Beat counter, 4 bits, wide enough for 15 remaining beats:
  - On an edge with HREADY=1 and HTRANS=NONSEQ, load beats-1 from HBURST: WRAP4/INCR4 give 3, WRAP8/INCR8 give 7, WRAP16/INCR16 give 15, SINGLE/INCR give 0.
  - Decrement on each edge with HREADY=1 and HTRANS=SEQ while the counter is nonzero; it never wraps below 0.
REQ-020 Early burst termination: if HTRANS is IDLE or NONSEQ with HREADY=1 while the counter is nonzero, the counter clears (or reloads on NONSEQ) and re-arbitration is permitted on that same edge.
REQ-021 BUSY with HREADY=1 leaves the counter unchanged.
REQ-022 HTRANS sampled with HREADY=0 has no effect; the counter, grant, HMASTER and HMASTER_D all hold.
REQ-023 HMASTLOCK loads the granted master's HLOCK on each edge with HREADY=1, so it is aligned with HMASTER.
REQ-024 Simultaneous events, same edge: counter reaching 0 together with a higher-priority request → the grant moves on the next HREADY=1 edge after the count reaches 0, never earlier.
REQ-025 Lock takes precedence over round-robin fairness; a master holding HLOCK=1 keeps the bus indefinitely.

Reset
REQ-026 While HRESETn=0 at a rising HCLK edge, all state loads reset values:
  - grant = DEF_MASTER (one-hot);
  - HMASTER = HMASTER_D = DEF_MASTER;
  - HMASTLOCK = 0;
  - beat counter = 0;
  - round-robin pointer = DEF_MASTER.
REQ-027 Reset asserted mid-burst or mid-lock abandons the hold immediately; the first edge after release arbitrates normally.
REQ-028 Outputs are undefined only before the first reset edge; no asynchronous reset path exists.

Structure
REQ-029 A shared package (ahb_defs) holds the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), the HBURST encodings and the PRIO_MODE constants.
REQ-030 One sub-module, ahb_burst_cnt, contains the beat counter and the HBURST decode; the arbitration logic and output registers stay in ahb_arb_m2.
REQ-031 The block replaces the arbiter inside the two-master interconnect without port changes to the masters.

Verification
REQ-032 Reset: hold HRESETn=0 for 2 cycles with DEF_MASTER=0 → M0_HGRANT=1, M1_HGRANT=0, HMASTER=0, HMASTER_D=0, HMASTLOCK=0.
REQ-033 Fixed priority: M0 and M1 request together, HREADY=1 → grant M1 after 1 edge, HMASTER=1 after 2 edges, HMASTER_D=1 after 3 edges.
REQ-034 Burst hold: M0 owns the bus and issues NONSEQ with HBURST=INCR4; M1 requests at beat 2 → grant moves to M1 only on the edge after the 4th beat; a wait state (HREADY=0) inserted at beat 3 delays the handover by 1 cycle.
REQ-035 Early termination: M0 issues INCR8, then IDLE after 3 beats with M1 requesting → M1 granted on that IDLE edge.
REQ-036 Lock: M0 asserts M0_HLOCK with M1 requesting for 10 cycles → M0 keeps the grant and HMASTLOCK=1 aligned to HMASTER=0; M1 is granted one edge after M0_HLOCK drops.
REQ-037 Round-robin (PRIO_MODE=1): both masters request continuously with SINGLE transfers → grants alternate 1,0,1,0 on successive HREADY=1 edges; reset asserted mid-INCR16 → counter=0 and grant=DEF_MASTER one edge later.
